// File: rtl/vv_loader_pkg.sv
// Shared definitions for the vector-vector loader and the ops unit it feeds.
//   loader_state_e : loader FSM states
//   vv_op_t/VV_*   : op codes understood by the vv_ops datapath
//   DEF_*          : default element width and vector length
package vv_loader_pkg;

    localparam int unsigned DEF_BITS    = 8;
    localparam int unsigned DEF_VEC_LEN = 4;

    typedef logic [1:0] vv_op_t;

    localparam vv_op_t VV_MUL    = 2'b00;
    localparam vv_op_t VV_ADD    = 2'b01;
    localparam vv_op_t VV_SUB_AB = 2'b10;
    localparam vv_op_t VV_SUB_BA = 2'b11;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } loader_state_e;

endpackage

// File: rtl/vv_loader_if.sv
// Element-stream input and operand-set output handshakes of the loader.
//   in_valid/in_ready/in_data/in_op           : scalar element stream
//   vec_a/vec_b/control/vec_valid/vec_ready   : operand set to the ops unit
// slave  = loader side, master = producer/consumer side.
interface vv_loader_if
    import vv_loader_pkg::*;
#(
    parameter int unsigned IN_BITS = DEF_BITS,
    parameter int unsigned VEC_LEN = DEF_VEC_LEN
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic signed [IN_BITS-1:0] in_data;
    vv_op_t                    in_op;
    logic signed [IN_BITS-1:0] vec_a [VEC_LEN];
    logic signed [IN_BITS-1:0] vec_b [VEC_LEN];
    vv_op_t                    control;
    logic                      vec_valid;
    logic                      vec_ready;

    modport slave (
        input  in_valid, in_data, in_op, vec_ready,
        output in_ready, vec_a, vec_b, control, vec_valid
    );

    modport master (
        output in_valid, in_data, in_op, vec_ready,
        input  in_ready, vec_a, vec_b, control, vec_valid
    );

endinterface

// File: rtl/vv_loader_vec_capture_reg.sv
// Indexed write-enable register array holding one operand vector.
//   clock, reset : clock and async active-high reset (clears all elements)
//   we, idx, din : write din into element idx when we is high
//   vec          : registered vector contents
module vv_loader_vec_capture_reg #(
    parameter int unsigned IN_BITS = 8,
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      we,
    input  logic [IDX_W-1:0]          idx,
    input  logic signed [IN_BITS-1:0] din,
    output logic signed [IN_BITS-1:0] vec [VEC_LEN]
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(VEC_LEN); i++) begin
                vec[i] <= '0;
            end
        end else if (we) begin
            vec[idx] <= din;
        end
    end

endmodule

// File: rtl/vv_loader.sv
// Packs a scalar element stream into operand vectors A and B plus op code
// for the vv_ops unit, and presents them with a valid/ready handshake.
//   clock, reset : clock and async active-high reset
//   abort        : synchronous flush of any partial load or pending set
//   busy         : partial load in progress
//   bus          : element stream in, operand set out (vv_loader_if.slave)
module vv_loader
    import vv_loader_pkg::*;
#(
    parameter int unsigned IN_BITS = DEF_BITS,
    parameter int unsigned VEC_LEN = DEF_VEC_LEN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        abort,
    output logic        busy,
    vv_loader_if.slave  bus
);

    localparam int unsigned       IDX_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VEC_LEN - 1);

    loader_state_e             state;
    logic [IDX_W-1:0]          idx;
    logic                      beat;
    logic                      we_a;
    logic                      we_b;
    logic signed [IN_BITS-1:0] vec_a_q [VEC_LEN];
    logic signed [IN_BITS-1:0] vec_b_q [VEC_LEN];

    // Ready depends only on state; held low while reset is asserted.
    assign bus.in_ready = !reset && (state != PRESENT);

    // abort drops a coincident element instead of storing it.
    assign beat = bus.in_valid && bus.in_ready && !abort;
    assign we_a = beat && (state == LOAD_A);
    assign we_b = beat && (state == LOAD_B);

    assign busy      = (idx != '0) || (state == LOAD_B);
    assign bus.vec_a = vec_a_q;
    assign bus.vec_b = vec_b_q;

    vv_loader_vec_capture_reg #(
        .IN_BITS(IN_BITS), .VEC_LEN(VEC_LEN), .IDX_W(IDX_W)
    ) u_cap_a (
        .clock(clock), .reset(reset), .we(we_a), .idx(idx),
        .din(bus.in_data), .vec(vec_a_q)
    );

    vv_loader_vec_capture_reg #(
        .IN_BITS(IN_BITS), .VEC_LEN(VEC_LEN), .IDX_W(IDX_W)
    ) u_cap_b (
        .clock(clock), .reset(reset), .we(we_b), .idx(idx),
        .din(bus.in_data), .vec(vec_b_q)
    );

    // Loader FSM: fill A, fill B, then hold the set until accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= LOAD_A;
            idx           <= '0;
            bus.control   <= VV_MUL;
            bus.vec_valid <= 1'b0;
        end else if (abort) begin
            state         <= LOAD_A;
            idx           <= '0;
            bus.vec_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (beat) begin
                        if (idx == '0) begin
                            bus.control <= bus.in_op;
                        end
                        if (idx == LAST_IDX) begin
                            state <= LOAD_B;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        if (idx == LAST_IDX) begin
                            state         <= PRESENT;
                            idx           <= '0;
                            bus.vec_valid <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (bus.vec_ready) begin
                        state         <= LOAD_A;
                        bus.vec_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD_A;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vv_loader.sv
// Directed self-checking bench for vv_loader (8-bit elements, 4-element vectors).
module tb_vv_loader;
    import vv_loader_pkg::*;

    localparam int unsigned BITS = 8;
    localparam int unsigned LEN  = 4;

    typedef logic signed [BITS-1:0] elem_t;
    typedef elem_t vec_t [LEN];

    logic clock;
    logic reset;
    logic abort;
    logic busy;

    int checks;
    int errors;

    vv_loader_if #(.IN_BITS(BITS), .VEC_LEN(LEN)) bus ();

    vv_loader #(.IN_BITS(BITS), .VEC_LEN(LEN)) dut (
        .clock(clock),
        .reset(reset),
        .abort(abort),
        .busy (busy),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_beat(input elem_t d, input vv_op_t op);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_op    = op;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic accept();
        bus.vec_ready = 1'b1;
        step();
        bus.vec_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.vec_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b vld=%b busy=%b want 0 0 0",
                     bus.in_ready, bus.vec_valid, busy);
        end
        for (int i = 0; i < int'(LEN); i++) begin
            checks++;
            if (bus.vec_a[i] !== elem_t'(0) || bus.vec_b[i] !== elem_t'(0)) begin
                errors++;
                $display("FAIL reset_vec[%0d] got a=%0d b=%0d want 0 0", i, bus.vec_a[i], bus.vec_b[i]);
            end
        end
        checks++;
        if (bus.control !== 2'b00) begin
            errors++;
            $display("FAIL reset_control got %b want 00", bus.control);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        vec_t a = '{1, 2, 3, 4};
        vec_t b = '{10, 20, 30, 40};
        for (int i = 0; i < int'(LEN); i++) drive_beat(a[i], VV_ADD);
        for (int i = 0; i < int'(LEN) - 1; i++) drive_beat(b[i], VV_MUL);
        checks++;
        if (bus.vec_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_last got vld=%b busy=%b want 0 1", bus.vec_valid, busy);
        end
        drive_beat(b[LEN-1], VV_MUL);
        checks++;
        if (bus.vec_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_present got vld=%b rdy=%b busy=%b want 1 0 0",
                     bus.vec_valid, bus.in_ready, busy);
        end
        checks++;
        if (bus.control !== VV_ADD) begin
            errors++;
            $display("FAIL basic_control got %b want 01", bus.control);
        end
        for (int i = 0; i < int'(LEN); i++) begin
            checks++;
            if (bus.vec_a[i] !== a[i] || bus.vec_b[i] !== b[i]) begin
                errors++;
                $display("FAIL basic_vec[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                         i, bus.vec_a[i], bus.vec_b[i], a[i], b[i]);
            end
        end
        // Offered elements must be ignored while the set is presented.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd77;
        bus.in_op    = VV_SUB_BA;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (bus.vec_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.control !== VV_ADD ||
                bus.vec_a[0] !== a[0] || bus.vec_b[LEN-1] !== b[LEN-1]) begin
                errors++;
                $display("FAIL basic_hold cycle %0d got vld=%b rdy=%b ctl=%b a0=%0d b3=%0d want 1 0 01 1 40",
                         c, bus.vec_valid, bus.in_ready, bus.control, bus.vec_a[0], bus.vec_b[LEN-1]);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_accept_overwrite();
        vec_t a = '{-1, -2, -3, -4};
        vec_t b = '{5, 6, 7, 8};
        accept();
        checks++;
        if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.control !== VV_ADD) begin
            errors++;
            $display("FAIL accept got vld=%b rdy=%b ctl=%b want 0 1 01",
                     bus.vec_valid, bus.in_ready, bus.control);
        end
        drive_beat(a[0], VV_SUB_BA);
        checks++;
        if (bus.control !== VV_SUB_BA || bus.vec_a[0] !== a[0] || bus.vec_a[1] !== elem_t'(2)) begin
            errors++;
            $display("FAIL overwrite_first got ctl=%b a0=%0d a1=%0d want 11 -1 2",
                     bus.control, bus.vec_a[0], bus.vec_a[1]);
        end
        for (int i = 1; i < int'(LEN); i++) drive_beat(a[i], VV_MUL);
        for (int i = 0; i < int'(LEN); i++) drive_beat(b[i], VV_ADD);
        checks++;
        if (bus.vec_valid !== 1'b1 || bus.control !== VV_SUB_BA) begin
            errors++;
            $display("FAIL overwrite_present got vld=%b ctl=%b want 1 11", bus.vec_valid, bus.control);
        end
        for (int i = 0; i < int'(LEN); i++) begin
            checks++;
            if (bus.vec_a[i] !== a[i] || bus.vec_b[i] !== b[i]) begin
                errors++;
                $display("FAIL overwrite_vec[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                         i, bus.vec_a[i], bus.vec_b[i], a[i], b[i]);
            end
        end
        accept();
    endtask

    task automatic test_gapped();
        vec_t a = '{1, 2, 3, 4};
        vec_t b = '{10, 20, 30, 40};
        elem_t d;
        for (int i = 0; i < 2 * int'(LEN); i++) begin
            d = (i < int'(LEN)) ? a[i] : b[i - int'(LEN)];
            if (i == 2 * int'(LEN) - 1) begin
                checks++;
                if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL gapped_pre_last got vld=%b rdy=%b want 0 1", bus.vec_valid, bus.in_ready);
                end
            end
            drive_beat(d, VV_ADD);
            if (i < 2 * int'(LEN) - 1) step();
        end
        checks++;
        if (bus.vec_valid !== 1'b1 || bus.control !== VV_ADD) begin
            errors++;
            $display("FAIL gapped_present got vld=%b ctl=%b want 1 01", bus.vec_valid, bus.control);
        end
        for (int i = 0; i < int'(LEN); i++) begin
            checks++;
            if (bus.vec_a[i] !== a[i] || bus.vec_b[i] !== b[i]) begin
                errors++;
                $display("FAIL gapped_vec[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                         i, bus.vec_a[i], bus.vec_b[i], a[i], b[i]);
            end
        end
        accept();
    endtask

    task automatic test_abort();
        vec_t a = '{11, 12, 13, 14};
        vec_t b = '{21, 22, 23, 24};
        for (int i = 1; i <= 4; i++) drive_beat(elem_t'(i), VV_ADD);
        drive_beat(8'sd10, VV_MUL);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd99;
        abort        = 1'b1;
        step();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_flags got busy=%b vld=%b rdy=%b want 0 0 1",
                     busy, bus.vec_valid, bus.in_ready);
        end
        checks++;
        if (bus.vec_b[0] !== elem_t'(10) || bus.vec_b[1] !== elem_t'(20) || bus.control !== VV_ADD) begin
            errors++;
            $display("FAIL abort_kept got b0=%0d b1=%0d ctl=%b want 10 20 01",
                     bus.vec_b[0], bus.vec_b[1], bus.control);
        end
        for (int i = 0; i < int'(LEN); i++) drive_beat(a[i], VV_SUB_AB);
        for (int i = 0; i < int'(LEN); i++) drive_beat(b[i], VV_SUB_AB);
        checks++;
        if (bus.vec_valid !== 1'b1 || bus.control !== VV_SUB_AB) begin
            errors++;
            $display("FAIL abort_reload got vld=%b ctl=%b want 1 10", bus.vec_valid, bus.control);
        end
        for (int i = 0; i < int'(LEN); i++) begin
            checks++;
            if (bus.vec_a[i] !== a[i] || bus.vec_b[i] !== b[i]) begin
                errors++;
                $display("FAIL abort_vec[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                         i, bus.vec_a[i], bus.vec_b[i], a[i], b[i]);
            end
        end
        accept();
    endtask

    task automatic test_async_reset();
        drive_beat(8'sd7, VV_SUB_BA);
        drive_beat(8'sd8, VV_MUL);
        drive_beat(8'sd9, VV_MUL);
        checks++;
        if (busy !== 1'b1 || bus.control !== VV_SUB_BA || bus.vec_a[2] !== elem_t'(9)) begin
            errors++;
            $display("FAIL areset_pre got busy=%b ctl=%b a2=%0d want 1 11 9",
                     busy, bus.control, bus.vec_a[2]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.vec_a[0] !== elem_t'(0) || bus.vec_a[2] !== elem_t'(0) || bus.vec_b[0] !== elem_t'(0) ||
            bus.control !== 2'b00) begin
            errors++;
            $display("FAIL areset_data got a0=%0d a2=%0d b0=%0d ctl=%b want 0 0 0 00",
                     bus.vec_a[0], bus.vec_a[2], bus.vec_b[0], bus.control);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.vec_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_flags got rdy=%b vld=%b busy=%b want 0 0 0",
                     bus.in_ready, bus.vec_valid, busy);
        end
        #3;
        reset = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.vec_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_release got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.vec_valid, busy);
        end
    endtask

    task automatic test_extremes();
        int    ea [LEN] = '{-128, 127, 0, -1};
        int    eb [LEN] = '{127, -128, -1, 0};
        for (int i = 0; i < int'(LEN); i++) drive_beat(elem_t'(ea[i]), VV_SUB_AB);
        for (int i = 0; i < int'(LEN); i++) drive_beat(elem_t'(eb[i]), VV_MUL);
        checks++;
        if (bus.vec_valid !== 1'b1 || bus.control !== VV_SUB_AB) begin
            errors++;
            $display("FAIL extremes_present got vld=%b ctl=%b want 1 10", bus.vec_valid, bus.control);
        end
        checks++;
        if (bus.vec_a[0] !== 8'h80 || bus.vec_a[1] !== 8'h7f || bus.vec_b[2] !== 8'hff) begin
            errors++;
            $display("FAIL extremes_bits got a0=%h a1=%h b2=%h want 80 7f ff",
                     bus.vec_a[0], bus.vec_a[1], bus.vec_b[2]);
        end
        for (int i = 0; i < int'(LEN); i++) begin
            checks++;
            if (int'(bus.vec_a[i]) != ea[i] || int'(bus.vec_b[i]) != eb[i]) begin
                errors++;
                $display("FAIL extremes_signed[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                         i, int'(bus.vec_a[i]), int'(bus.vec_b[i]), ea[i], eb[i]);
            end
        end
        accept();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = VV_MUL;
        bus.vec_ready = 1'b0;

        test_reset();
        test_basic();
        test_accept_overwrite();
        test_gapped();
        test_abort();
        test_async_reset();
        test_extremes();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vv_loader.md
Name: vv_loader

Overview:
- Input-side counterpart to the vector-vector ops unit: turns a scalar element stream into the two operand vectors plus op code that the unit consumes.
- Accepts one signed element per handshake, filling vec_a and then vec_b (element 0 first).
- Presents the completed operand set with a valid/ready handshake and holds it stable until it is accepted.
- Sits between the scalar input fabric and the vv_ops datapath.

Parameters:
- IN_BITS, `BITS, width of one signed element.
- VEC_LEN, `VEC_LEN, number of elements per vector (>= 2).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- abort  input  1  synchronous flush; discards any partial load.
- in_valid  input  1  in_data/in_op valid.
- in_ready  output  1  loader accepts an element this cycle.
- in_data  input  IN_BITS signed  element value.
- in_op  input  2  op code; sampled only on the first beat of vec_a.
- vec_a  output  IN_BITS signed x VEC_LEN  operand A (unpacked array).
- vec_b  output  IN_BITS signed x VEC_LEN  operand B (unpacked array).
- control  output  2  op code for the ops unit.
- vec_valid  output  1  operands complete and stable.
- vec_ready  input  1  downstream accepts operands.
- busy  output  1  partial load in progress (idx != 0 or state LOAD_B).

Behaviour:
- One clock, asynchronous active-high reset.
- Reset values:
  - state = LOAD_A, idx = 0.
  - All vec_a/vec_b elements = 0, control = 2'b00, vec_valid = 0, busy = 0.
  - in_ready = 0 while reset is asserted.
- Handshakes:
  - Input beat occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when vec_valid && vec_ready.
- in_ready is combinational from state only: 1 in LOAD_A and LOAD_B, 0 in PRESENT. It never depends on in_valid.
- vec_a, vec_b, control and vec_valid are registered. vec_valid asserts in the cycle after the last B beat.
- FSM:
  - LOAD_A:
    - Each beat writes in_data to vec_a[idx].
    - On a beat with idx==0, control <= in_op.
    - idx==VEC_LEN-1 on a beat -> LOAD_B, idx <= 0; otherwise idx++.
  - LOAD_B:
    - Each beat writes in_data to vec_b[idx].
    - idx==VEC_LEN-1 on a beat -> PRESENT, vec_valid <= 1, idx <= 0; otherwise idx++.
  - PRESENT:
    - vec_a, vec_b and control are frozen.
    - On vec_ready: vec_valid <= 0, -> LOAD_A.
    - No input beat can occur in this state (in_ready = 0).
- Vector contents are never cleared after load; stale elements remain visible until overwritten. Consumers qualify with vec_valid only.
- Latency:
  - 2*VEC_LEN input beats to vec_valid, plus 1 cycle.
  - Minimum sustained period is 2*VEC_LEN + 1 cycles per operand set, because the PRESENT/accept cycle is not overlapped.
- abort (synchronous, any state):
  - Next state LOAD_A, idx <= 0, vec_valid <= 0.
  - Element and control registers keep their values.
  - abort overrides a simultaneous input beat (the element is dropped, not written).
  - abort overrides a simultaneous output transfer (it is treated as discarded).
- Reset mid-load: immediate return to reset values; no partial data survives.
- Width: in_data is stored without extension or truncation. control takes in_op verbatim; all 4 codes are legal.

Decomposition:
- Shared package:
  - loader state enum {LOAD_A, LOAD_B, PRESENT}.
  - op-code constants VV_MUL=2'b00, VV_ADD=2'b01, VV_SUB_AB=2'b10, VV_SUB_BA=2'b11.
  - The ops unit imports the same op-code constants.
  - `BITS / `VEC_LEN remain in constants.vh.
- One natural sub-module, vec_capture_reg: an indexed write-enable register array (clock, reset, we, idx, din -> vec), instantiated once for A and once for B.

Test Plan (BITS=8, VEC_LEN=4):
- Reset then stream A={1,2,3,4} op=01, B={10,20,30,40}, in_valid continuous, vec_ready=0:
  - vec_valid rises 1 cycle after the 8th beat.
  - vec_a={1,2,3,4}, vec_b={10,20,30,40}, control=01.
  - in_ready=0 and outputs hold for 20 cycles.
- Assert vec_ready 1 cycle in the previous state:
  - vec_valid falls next cycle, in_ready=1.
  - New stream A={-1,-2,-3,-4} op=11 overwrites; control=11 only after the first A beat.
- Gapped input (in_valid toggling 1/0) with the same data as the first test:
  - Identical final vectors; vec_valid is delayed by the number of idle cycles.
- abort after 5 beats, coincident with the 6th beat (value 99):
  - Next cycle state LOAD_A, idx=0, busy=0, 99 not stored.
  - A full reload then yields the correct vectors.
- Assert reset asynchronously (mid-cycle) after 3 beats:
  - All outputs 0 immediately; after release in_ready=1, vec_valid=0.
- Extremes A={-128,127,0,-1}, B={127,-128,-1,0}, op=10:
  - Stored bit-exact; signed readback matches.
